// File: rtl/issue_arbiter_pkg.sv
// rtl/issue_arbiter_pkg.sv - issue arbiter defaults and shared one-hot encoder
// Shared with IBuffer_wrapper and the scoreboard so every block encodes warp IDs identically.
package issue_arbiter_pkg;

  localparam int DEF_NUM_WARPS    = 8;
  localparam int DEF_LOGNUM_WARPS = $clog2(DEF_NUM_WARPS);
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int MAX_WARPS        = 64;

  // OR-reduction of set-bit indices; exact for a one-hot input, 0 for an all-zero input.
  function automatic int onehot_enc(input logic [MAX_WARPS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_WARPS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/issue_arbiter_rr_priority_arbiter.sv
// rtl/issue_arbiter_rr_priority_arbiter.sv - one-hot find-first starting at ptr, wrapping
// Works for any N, not only powers of two, by wrapping the search index explicitly.
module rr_priority_arbiter
  import issue_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_WARPS,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grt
);

  always_comb begin
    logic found;
    int   idx;
    grt   = '0;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_arbiter.sv
// rtl/issue_arbiter.sv - warp issue arbiter, round-robin by default
// Defining ISSUE_GTO_EN builds greedy-then-oldest with a starvation guard.
module issue_arbiter
  import issue_arbiter_pkg::*;
#(
  parameter int NUM_WARPS    = DEF_NUM_WARPS,
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS),
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WARPS-1:0]    req_IB_IU,
  input  logic                    stall_OC_IU,
  output logic [NUM_WARPS-1:0]    grt_IU_IB,
  output logic                    valid_IU_OC,
  output logic [LOGNUM_WARPS-1:0] warpID_IU_OC
);

  logic [LOGNUM_WARPS-1:0] rr_ptr_q, rr_ptr_d;
  logic                    valid_q, valid_d;
  logic [LOGNUM_WARPS-1:0] warp_q, warp_d;
  logic [NUM_WARPS-1:0]    rr_grt, pick;
  logic [LOGNUM_WARPS-1:0] grt_id;
  logic                    grt_any;

  rr_priority_arbiter #(.N(NUM_WARPS), .PW(LOGNUM_WARPS)) u_rr (
    .req (req_IB_IU),
    .ptr (rr_ptr_q),
    .grt (rr_grt)
  );

`ifdef ISSUE_GTO_EN
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]           age_q [NUM_WARPS];
  logic [AW-1:0]           age_d [NUM_WARPS];
  logic [LOGNUM_WARPS-1:0] last_warp_q, last_warp_d;
  logic                    last_valid_q, last_valid_d;
  logic [NUM_WARPS-1:0]    starved, starve_grt;

  always_comb begin
    starved = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      starved[w] = req_IB_IU[w] && (age_q[w] == AW'(STARVE_LIMIT));
    end
  end

  rr_priority_arbiter #(.N(NUM_WARPS), .PW(LOGNUM_WARPS)) u_starve (
    .req (starved),
    .ptr (rr_ptr_q),
    .grt (starve_grt)
  );

  always_comb begin
    pick = '0;
    if (|starved) begin
      pick = starve_grt;
    end else if (last_valid_q && req_IB_IU[last_warp_q]) begin
      pick[last_warp_q] = 1'b1;
    end else begin
      pick = rr_grt;
    end
  end
`else
  assign pick = rr_grt;
`endif

  assign grt_IU_IB = (rst || stall_OC_IU) ? '0 : pick;
  assign grt_any   = |grt_IU_IB;
  assign grt_id    = LOGNUM_WARPS'(onehot_enc(MAX_WARPS'(grt_IU_IB)));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    warp_d   = warp_q;
    valid_d  = grt_any;
    if (grt_any) begin
      warp_d   = grt_id;
      rr_ptr_d = (grt_id == LOGNUM_WARPS'(NUM_WARPS - 1)) ? '0 : grt_id + 1'b1;
    end
  end

`ifdef ISSUE_GTO_EN
  // Ages advance on stall cycles too, so a stalled backlog still reaches the starvation bound.
  always_comb begin
    last_warp_d  = grt_any ? grt_id : last_warp_q;
    last_valid_d = last_valid_q | grt_any;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (!req_IB_IU[w] || grt_IU_IB[w]) begin
        age_d[w] = '0;
      end else if (age_q[w] != AW'(STARVE_LIMIT)) begin
        age_d[w] = age_q[w] + 1'b1;
      end else begin
        age_d[w] = age_q[w];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_warp_q  <= '0;
      last_valid_q <= 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) age_q[w] <= '0;
    end else begin
      last_warp_q  <= last_warp_d;
      last_valid_q <= last_valid_d;
      for (int w = 0; w < NUM_WARPS; w++) age_q[w] <= age_d[w];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      warp_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      warp_q   <= warp_d;
    end
  end

  assign valid_IU_OC  = valid_q;
  assign warpID_IU_OC = warp_q;

endmodule

// File: tb/tb_issue_arbiter.sv
// tb/tb_issue_arbiter.sv - directed bench for issue_arbiter (round-robin build)
module tb_issue_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       stall;
  logic [7:0] grt;
  logic       valid;
  logic [2:0] wid;

  int checks;
  int failures;

  issue_arbiter #(.NUM_WARPS(8), .LOGNUM_WARPS(3), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_IB_IU    (req),
    .stall_OC_IU  (stall),
    .grt_IU_IB    (grt),
    .valid_IU_OC  (valid),
    .warpID_IU_OC (wid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge; settle time lets combinational outputs follow new inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = 8'hFF;
    stall    = 1'b0;

    // Reset
    tick();
    tick();
    settle();
    check("rst_grt", 32'(grt), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_wid", 32'(wid), 32'h0);

    // Round-robin over all requesters, wrapping back to warp 0
    rst = 1'b0;
    settle();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("rr_grt_%0d", i), 32'(grt), 32'(8'h01 << (i % 8)));
      tick();
      check($sformatf("rr_valid_%0d", i), 32'(valid), 32'h1);
      check($sformatf("rr_wid_%0d", i), 32'(wid), 32'(i % 8));
    end

    // No request -> no grant; rr_ptr is 1
    req = 8'h00;
    settle();
    check("noreq_grt", 32'(grt), 32'h00);
    tick();
    check("noreq_valid", 32'(valid), 32'h0);
    check("noreq_wid_hold", 32'(wid), 32'h0);

    // Wrap/sparse: grant warp 6, then req 41 gives 01 then 40
    req = 8'h40;
    settle();
    check("wrap_g6", 32'(grt), 32'h40);
    tick();
    req = 8'h41;
    settle();
    check("wrap_g0", 32'(grt), 32'h01);
    tick();
    check("wrap_wid0", 32'(wid), 32'h0);
    check("wrap_g6b", 32'(grt), 32'h40);
    tick();
    check("wrap_wid6", 32'(wid), 32'h6);

    // Stall with rr_ptr=3 (after granting warp 2)
    req = 8'h04;
    settle();
    check("stall_pre", 32'(grt), 32'h04);
    tick();
    req   = 8'hFF;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("stall_grt_%0d", i), 32'(grt), 32'h00);
      tick();
      check($sformatf("stall_valid_%0d", i), 32'(valid), 32'h0);
      check($sformatf("stall_wid_%0d", i), 32'(wid), 32'h2);
    end
    stall = 1'b0;
    settle();
    check("stall_release", 32'(grt), 32'h08);
    tick();
    check("stall_rel_wid", 32'(wid), 32'h3);

    // Single requester, rr_ptr=4
    req = 8'h10;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("single_grt_%0d", i), 32'(grt), 32'h10);
      tick();
      check($sformatf("single_valid_%0d", i), 32'(valid), 32'h1);
      check($sformatf("single_wid_%0d", i), 32'(wid), 32'h4);
    end

    // Round-robin build with the greedy stimulus: grant 2, then 24 alternates starting at warp 5
    req = 8'h04;
    settle();
    check("alt_pre", 32'(grt), 32'h04);
    tick();
    req = 8'h24;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("alt_grt_%0d", i), 32'(grt), (i % 2 == 0) ? 32'h20 : 32'h04);
      tick();
    end

    // Mid-operation reset; rr_ptr is now 3 but must clear
    req = 8'hFF;
    rst = 1'b1;
    settle();
    check("midrst_grt", 32'(grt), 32'h00);
    tick();
    check("midrst_valid", 32'(valid), 32'h0);
    check("midrst_wid", 32'(wid), 32'h0);
    rst = 1'b0;
    settle();
    check("midrst_first", 32'(grt), 32'h01);
    tick();
    check("midrst_valid1", 32'(valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
